acc_cpu_core: RTL and testbench
===============================

ACC_CPU_CORE -- requirements
Module: acc_cpu_core

Interface
REQ-001 Parameter DW, default 8: accumulator and operand data width in bits (>=4).
REQ-002 Parameter AW, default 8: program counter and instruction address width in bits (>=2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  start/continue execution when 1; pause at the next instruction boundary when 0.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_addr  output  AW  fetch address; always equals pc.
REQ-008 imem_ack  input  1  fetch accepted; imem_rdata valid in the same cycle.
REQ-009 imem_rdata  input  4+DW  instruction word: [DW+3:DW] = opcode, [DW-1:0] = data.
REQ-010 acc  output  DW  accumulator.
REQ-011 pc  output  AW  program counter.
REQ-012 carry  output  1  carry/borrow flag.
REQ-013 zero  output  1  zero flag.
REQ-014 halted  output  1  core stopped by HLT.

Function
REQ-015 FSM states: IDLE, FETCH, EXEC, HALT; the outputs are registered, and imem_req is a pure decode of state == FETCH.
REQ-016 IDLE: go to FETCH when run=1, otherwise stay in IDLE.
REQ-017 FETCH: imem_req=1 with imem_addr held stable; on imem_ack=1, latch imem_rdata and go to EXEC; otherwise stay in FETCH, unaffected by run.
REQ-018 EXEC: execute the latched instruction in exactly one cycle, then go to FETCH if run=1, IDLE if run=0, HALT if opcode=HLT.
REQ-019 HALT: terminal state; halted=1 and imem_req=0 until reset; run is ignored.
REQ-020 imem_ack outside FETCH is ignored.
REQ-021 Latency: a zero-wait fetch gives 2 cycles per instruction; each cycle imem_ack is delayed adds one cycle.
REQ-022 Opcode 0x0 NOP: no state change apart from the pc update.
REQ-023 Opcode 0x1 LDI: acc=data.
REQ-024 Opcode 0x2 ADD: {carry,acc}=acc+data.
REQ-025 Opcode 0x3 SUB: acc=acc-data mod 2^DW; carry=1 iff data>acc (borrow).
REQ-026 Opcode 0x4 AND, 0x5 OR, 0x6 XOR: acc = acc op data.
REQ-027 Opcode 0x7 ADC: {carry,acc}=acc+data+carry.
REQ-028 Opcode 0xC CLR: acc=0.
REQ-029 Opcode 0x8 JMP: pc=data.
REQ-030 Opcode 0x9 JZ: pc=data if zero=1, else pc+1.
REQ-031 Opcode 0xA JC: pc=data if carry=1, else pc+1.
REQ-032 Opcode 0xB JREL: pc=pc+data mod 2^AW.
REQ-033 Opcode 0xF HLT: pc, acc and flags unchanged.
REQ-034 Opcodes 0xD and 0xE execute as NOP.
REQ-035 Width rule: data is used as pc by truncating to AW bits or zero-extending to AW bits.
REQ-036 Flag rules: every opcode that writes acc (0x1-0x7, 0xC) sets zero=(new acc==0); only ADD/SUB/ADC update carry; jumps, NOP and HLT leave both flags unchanged.
REQ-037 pc increments by 1 for every non-jump, non-HLT instruction; increments wrap 2^AW-1 -> 0.
REQ-038 JZ/JC test flag values from before the current instruction.

Reset
REQ-039 reset=0 immediately forces: state=IDLE, pc=0, acc=0, carry=0, zero=0, halted=0, imem_req=0, latched instruction=0, regardless of the clock.
REQ-040 Reset during FETCH drops imem_req in the same cycle; a pending ack is discarded.
REQ-041 After reset deasserts, no fetch occurs until run=1 is sampled in IDLE.

Verification (DW=8, AW=8)
REQ-042 Program LDI 0xF0; ADD 0x20; zero-wait ack -> acc=0x10, carry=1, zero=0, pc=2 after 4 cycles from first imem_req.
REQ-043 Program LDI 0x05; SUB 0x05; SUB 0x01 -> after the first SUB: acc=0x00, zero=1, carry=0; after the second SUB: acc=0xFF, zero=0, carry=1.
REQ-044 Program CLR; JZ 0x10 -> pc=0x10; program LDI 0x01; JZ 0x10 -> pc=2.
REQ-045 Ack delayed 3 cycles -> imem_req held 4 cycles, imem_addr stable throughout, instruction completes in 5 cycles; run=0 during the wait -> the instruction still executes, then the core enters IDLE with imem_req=0.
REQ-046 reset pulsed low mid-FETCH -> imem_req=0 and pc=0 before the next clk edge; the core stays in IDLE while run=0.
REQ-047 JMP 0xFF then NOP -> pc wraps to 0x00; HLT -> halted=1, imem_req stays 0 over 20 cycles with run toggling.

Source files
------------

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: fetch/execute FSM with a 16-opcode ALU and branch unit.
// Latency: 2 cycles per instruction with a zero-wait fetch, +1 per cycle imem_ack is late.
// Backpressure: FETCH holds imem_req/imem_addr until imem_ack; run=0 pauses at the next boundary.
module acc_cpu_core #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW+3:0] imem_rdata,
  output logic [DW-1:0] acc,
  output logic [AW-1:0] pc,
  output logic          carry,
  output logic          zero,
  output logic          halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_ADC  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_JREL = 4'hB;
  localparam logic [3:0] OP_CLR  = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hF;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;
  logic [DW+3:0] ir_q, ir_d;

  logic [3:0]    op;
  logic [DW-1:0] dat;
  logic [AW-1:0] dat_pc;
  logic [AW-1:0] pc_inc;
  logic [DW:0]   add_r;
  logic [DW:0]   adc_r;
  logic [DW:0]   sub_r;
  logic          acc_wr;

  assign op     = ir_q[DW+3:DW];
  assign dat    = ir_q[DW-1:0];
  assign dat_pc = AW'(dat);
  assign pc_inc = pc_q + AW'(1);

  // Bit DW of each result is the carry out; for SUB it is the borrow.
  assign add_r = {1'b0, acc_q} + {1'b0, dat};
  assign adc_r = add_r + {{DW{1'b0}}, carry_q};
  assign sub_r = {1'b0, acc_q} - {1'b0, dat};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    ir_d    = ir_q;
    acc_wr  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        pc_d = pc_inc;
        unique case (op)
          OP_LDI: begin acc_d = dat;           acc_wr = 1'b1; end
          OP_ADD: begin {carry_d, acc_d} = add_r; acc_wr = 1'b1; end
          OP_SUB: begin {carry_d, acc_d} = sub_r; acc_wr = 1'b1; end
          OP_AND: begin acc_d = acc_q & dat;   acc_wr = 1'b1; end
          OP_OR:  begin acc_d = acc_q | dat;   acc_wr = 1'b1; end
          OP_XOR: begin acc_d = acc_q ^ dat;   acc_wr = 1'b1; end
          OP_ADC: begin {carry_d, acc_d} = adc_r; acc_wr = 1'b1; end
          OP_CLR: begin acc_d = '0;            acc_wr = 1'b1; end
          OP_JMP:  pc_d = dat_pc;
          OP_JZ:   pc_d = zero_q  ? dat_pc : pc_inc;
          OP_JC:   pc_d = carry_q ? dat_pc : pc_inc;
          OP_JREL: pc_d = pc_q + dat_pc;
          OP_HLT:  pc_d = pc_q;
          default: ;
        endcase
        if (acc_wr) zero_d = (acc_d == '0);
        if (op == OP_HLT)  state_d = S_HALT;
        else if (run)      state_d = S_FETCH;
        else               state_d = S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ir_q    <= ir_d;
    end
  end

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign acc       = acc_q;
  assign pc        = pc_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: ISA reference model feeds a scoreboard on each fetch ack,
// results are popped and compared when the DUT finishes the instruction.
module tb_acc_cpu_core;

  logic        clk;
  logic        reset;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [11:0] imem_rdata;
  logic [7:0]  acc;
  logic [7:0]  pc;
  logic        carry;
  logic        zero;
  logic        halted;

  acc_cpu_core #(.DW(8), .AW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .acc        (acc),
    .pc         (pc),
    .carry      (carry),
    .zero       (zero),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int pc;
    int c;
    int z;
    int h;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] mem [256];
  int          n_chk = 0;
  int          n_pass = 0;
  int          m_pc, m_acc, m_c, m_z, m_h;

  task automatic chk(input string tag, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
  endtask

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_c = 0; m_z = 0; m_h = 0;
  endtask

  function automatic void model(input logic [11:0] ins);
    int op, d, s;
    op = int'(ins[11:8]);
    d  = int'(ins[7:0]);
    case (op)
      1:  begin m_acc = d; m_z = (m_acc == 0); end
      2:  begin s = m_acc + d; m_c = s / 256; m_acc = s % 256; m_z = (m_acc == 0); end
      3:  begin m_c = (d > m_acc); m_acc = (m_acc - d + 256) % 256; m_z = (m_acc == 0); end
      4:  begin m_acc = m_acc & d; m_z = (m_acc == 0); end
      5:  begin m_acc = m_acc | d; m_z = (m_acc == 0); end
      6:  begin m_acc = m_acc ^ d; m_z = (m_acc == 0); end
      7:  begin s = m_acc + d + m_c; m_c = s / 256; m_acc = s % 256; m_z = (m_acc == 0); end
      12: begin m_acc = 0; m_z = 1; end
      8:  m_pc = d;
      9:  m_pc = m_z ? d : (m_pc + 1) % 256;
      10: m_pc = m_c ? d : (m_pc + 1) % 256;
      11: m_pc = (m_pc + d) % 256;
      15: m_h = 1;
      default: ;
    endcase
    if (op < 8 || (op >= 12 && op <= 14)) m_pc = (m_pc + 1) % 256;
  endfunction

  // One instruction: wait for the fetch, stall wt cycles, ack, then check EXEC and the result.
  task automatic step(input int wt, input bit drop_run);
    int          n;
    int          bad;
    logic [7:0]  a0;
    logic [11:0] ins;
    exp_t        e;
    n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) begin
      chk("req_timeout", 0, 1);
      return;
    end
    chk("fetch_addr", imem_addr, m_pc);
    a0  = imem_addr;
    bad = 0;
    if (drop_run) run = 1'b0;
    for (int w = 0; w < wt; w++) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== a0) bad++;
    end
    if (wt > 0) chk("wait_hold", bad, 0);
    ins        = mem[a0];
    imem_rdata = ins;
    imem_ack   = 1'b1;
    model(ins);
    sb.push_back('{m_acc, m_pc, m_c, m_z, m_h});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 12'hFFF;
    chk("exec_req", imem_req, 0);
    @(negedge clk);
    e = sb.pop_front();
    chk("acc", acc, e.acc);
    chk("pc", pc, e.pc);
    chk("carry", carry, e.c);
    chk("zero", zero, e.z);
    chk("halted", halted, e.h);
    chk("next_req", imem_req, (run && e.h == 0) ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    reset      = 1'b0;
    run        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 12'hFFF;
    for (int i = 0; i < 256; i++) mem[i] = 12'h000;
    mem[8'h00] = 12'h1F0; // LDI F0
    mem[8'h01] = 12'h220; // ADD 20
    mem[8'h02] = 12'h105; // LDI 05
    mem[8'h03] = 12'h305; // SUB 05
    mem[8'h04] = 12'h301; // SUB 01
    mem[8'h05] = 12'hC00; // CLR
    mem[8'h06] = 12'h910; // JZ 10
    mem[8'h10] = 12'h101; // LDI 01
    mem[8'h11] = 12'h910; // JZ 10 (not taken)
    mem[8'h12] = 12'h77F; // ADC 7F
    mem[8'h13] = 12'hA30; // JC 30 (not taken)
    mem[8'h14] = 12'h280; // ADD 80
    mem[8'h15] = 12'hA20; // JC 20
    mem[8'h20] = 12'h40F; // AND 0F
    mem[8'h21] = 12'h5F0; // OR F0
    mem[8'h22] = 12'h6F1; // XOR F1
    mem[8'h23] = 12'hD00; // reserved, runs as NOP
    mem[8'h24] = 12'hB10; // JREL 10
    mem[8'h34] = 12'h1AA; // LDI AA
    mem[8'h35] = 12'h8FF; // JMP FF

    repeat (2) @(negedge clk);
    chk("rst_acc", acc, 0);
    chk("rst_pc", pc, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 0);
    chk("rst_halted", halted, 0);
    chk("rst_req", imem_req, 0);
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("idle_no_run", imem_req, 0);

    run = 1'b1;
    for (int i = 0; i < 18; i++) step((i % 3 == 2) ? 1 : 0, 1'b0);

    step(3, 1'b1);
    repeat (3) @(negedge clk);
    chk("paused_req", imem_req, 0);
    chk("paused_pc", pc, 8'h35);

    run = 1'b1;
    step(0, 1'b0);
    mem[8'h00] = 12'hF00; // HLT
    step(0, 1'b0);
    step(2, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      @(negedge clk);
      if (imem_req !== 1'b0 || halted !== 1'b1) bad++;
    end
    chk("halt_hold", bad, 0);
    chk("halt_pc", pc, 0);

    reset = 1'b0;
    run   = 1'b0;
    #1;
    chk("rst_clears_halt", halted, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    mem[8'h00] = 12'h1F0;

    imem_rdata = 12'h155;
    imem_ack   = 1'b1;
    repeat (3) @(negedge clk);
    chk("ack_idle_req", imem_req, 0);
    chk("ack_idle_acc", acc, 0);
    imem_ack   = 1'b0;
    imem_rdata = 12'hFFF;

    run = 1'b1;
    step(0, 1'b0);
    chk("mid_fetch_req", imem_req, 1);
    imem_rdata = mem[8'h01];
    imem_ack   = 1'b1;
    reset      = 1'b0;
    #1;
    chk("midrst_req", imem_req, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_acc", acc, 0);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 12'hFFF;
    run        = 1'b0;
    reset      = 1'b1;
    model_reset();
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || acc !== 8'h00 || pc !== 8'h00 || carry !== 1'b0) bad++;
    end
    chk("post_rst_idle", bad, 0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
